// File: rtl/universal_reg.sv
// Universal shift/count register: hold, load, shift, rotate, count up/down, all on falling CLK_BAR.
// One falling edge per operation; no handshake, EN=0 stalls the register.
module universal_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK_BAR,
  input  logic             CLR,
  input  logic             PRE,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SER_L,
  input  logic             SER_R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBAR,
  output logic             SO_R,
  output logic             SO_L,
  output logic             TC,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] next_q;
  logic             wrap;

  always_comb begin
    next_q = Q;
    case (MODE)
      3'b000: next_q = Q;
      3'b001: next_q = D;
      3'b010: next_q = {SER_L, Q[WIDTH-1:1]};
      3'b011: next_q = {Q[WIDTH-2:0], SER_R};
      3'b100: next_q = {Q[0], Q[WIDTH-1:1]};
      3'b101: next_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
      3'b110: next_q = Q + ONE;
      3'b111: next_q = Q - ONE;
      default: next_q = Q;
    endcase
  end

  // TC looks only at MODE and Q so it can flag the coming wrap even while stalled.
  always_comb begin
    TC = 1'b0;
    if (MODE == 3'b110 && Q == ONES)
      TC = 1'b1;
    else if (MODE == 3'b111 && Q == '0)
      TC = 1'b1;
  end

  assign wrap = EN && (MODE[2:1] == 2'b11) && TC;

  always_ff @(negedge CLK_BAR) begin
    if (CLR) begin
      Q   <= RST_VAL;
      OVF <= 1'b0;
    end else if (PRE) begin
      Q   <= ONES;
      OVF <= 1'b0;
    end else if (!EN) begin
      Q   <= Q;
      OVF <= 1'b0;
    end else begin
      Q   <= next_q;
      OVF <= wrap;
    end
  end

  assign QBAR = ~Q;
  assign SO_R = Q[0];
  assign SO_L = Q[WIDTH-1];

endmodule

// File: doc/universal_reg.md
UNIVERSAL_REG -- requirements
Module: universal_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be legal for 2..32.
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded by CLR.
REQ-003 CLK_BAR  input  1  clock; all state SHALL update on the falling edge of CLK_BAR.
REQ-004 CLR  input  1  reset; synchronous, active-high; takes effect only at a falling CLK_BAR edge.
REQ-005 PRE  input  1  synchronous, active-high preset to all ones.
REQ-006 EN  input  1  operation enable; EN=0 SHALL hold all state.
REQ-007 MODE  input  3  operation select, decoded per REQ-012.
REQ-008 D  input  WIDTH  parallel load data.
REQ-009 SER_L, SER_R  input  1 each  serial-in bits for the shift-right and shift-left modes.
REQ-010 Q  output  WIDTH  register state; QBAR  output  WIDTH  SHALL always equal ~Q (combinational).
REQ-011 Outputs SHALL be as follows:
- SO_R, SO_L  output  1 each  combinational, equal to Q[0] and Q[WIDTH-1].
- TC  output  1  combinational terminal-count flag.
- OVF  output  1  registered wrap flag.

Function
REQ-012 MODE decode SHALL be:
- 000 hold
- 001 parallel load Q<=D
- 010 shift right, Q<={SER_L,Q[W-1:1]}
- 011 shift left, Q<={Q[W-2:0],SER_R}
- 100 rotate right
- 101 rotate left
- 110 count up
- 111 count down
REQ-013 Per-edge priority SHALL be CLR > PRE > EN=0 (hold) > MODE operation.
REQ-014 CLR and PRE asserted on the same edge: CLR SHALL win, giving Q=RST_VAL.
REQ-015 Count modes SHALL use modulo-2^WIDTH arithmetic; up from all-ones SHALL give 0, and down from 0 SHALL give all-ones.
REQ-016 TC SHALL be 1 when any of the following holds, else 0:
- MODE=110 and Q is all ones
- MODE=111 and Q=0
REQ-017 TC SHALL NOT be qualified by EN.
REQ-018 OVF SHALL be set to 1 for exactly one cycle on the edge where a count mode, with EN=1, wraps (TC=1 at that edge).
REQ-019 OVF SHALL otherwise be 0, including on edges where CLR or PRE is asserted.
REQ-020 Shift/rotate latency SHALL be one falling edge per bit position; no pipelining of Q.
REQ-021 MODE or D changes between edges SHALL have no effect on Q until the next falling CLK_BAR edge.
REQ-022 Rising CLK_BAR edges SHALL never change Q or OVF.

Reset
REQ-023 After any edge with CLR=1, the outputs SHALL be:
- Q=RST_VAL
- QBAR=~RST_VAL
- OVF=0
REQ-024 SO_L, SO_R and TC SHALL follow the reset Q through their combinational definitions.
REQ-025 CLR asserted mid-count or mid-shift SHALL abort the operation on that edge, with no partial update.
REQ-026 Before the first CLR edge, Q SHALL be treated as unknown; no power-up value is guaranteed.
REQ-027 PRE SHALL set Q to all ones and OVF to 0 on the edge, independent of EN.

Verification
REQ-028 WIDTH=8: CLR=1 for one falling edge -> Q=8'h00, QBAR=8'hFF, OVF=0.
REQ-029 MODE=001, D=8'hA5, EN=1 -> next edge Q=8'hA5; then MODE=010, SER_L=1 -> Q=8'hD2, SO_R=0.
REQ-030 Q=8'hFE, MODE=110, EN=1 -> the two edges SHALL give:
- edge 1: Q=8'hFF, TC=1
- edge 2: Q=8'h00, OVF=1
- one edge later: OVF=0
REQ-031 Q=8'h81, MODE=101 -> Q=8'h03; MODE=100 from 8'h81 -> Q=8'hC0.
REQ-032 CLR=1 and PRE=1 on the same edge with MODE=110 -> Q=RST_VAL, OVF=0; PRE alone -> Q=8'hFF.
REQ-033 EN=0 with MODE toggling through all eight codes for 8 edges -> Q unchanged; rising edges with EN=1 -> no change.
